// File: rtl/riscv_core_cache_pkg.sv
`default_nettype none
// ============================================================================
// Module      : riscv_core_cache_pkg
// Description : Shared types for the cache-to-memory arbitration slice.
//               Arbiter FSM states, grant identifiers and a small helper
//               that returns the opposite requester.
// Revision    : 1.0  initial release
// ============================================================================
package riscv_core_cache_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE    = 2'd0,
        ARB_BUSY    = 2'd1,
        ARB_RELEASE = 2'd2
    } arb_state_t;

    typedef enum logic {
        GNT_IC = 1'b0,
        GNT_DC = 1'b1
    } arb_gnt_t;

    // Bit positions of each requester in the packed request vector.
    localparam int unsigned c_REQ_IC = 0;
    localparam int unsigned c_REQ_DC = 1;

    function automatic arb_gnt_t other_gnt(input arb_gnt_t g);
        return (g == GNT_IC) ? GNT_DC : GNT_IC;
    endfunction

endpackage
`default_nettype wire

// File: rtl/riscv_core_rr_pick2.sv
`default_nettype none
// ============================================================================
// Module      : riscv_core_rr_pick2
// Description : Combinational 2-way round-robin picker.
//               A single requester always wins; on a tie the requester that
//               was NOT granted last time wins.
// Ports       : i_req   [1:0] request vector (bit0 = icache, bit1 = dcache)
//               i_last        requester granted most recently
//               o_gnt         selected requester
//               o_valid       at least one request present
// Revision    : 1.0  initial release
// ============================================================================
module riscv_core_rr_pick2
    import riscv_core_cache_pkg::*;
(
    input  logic [1:0] i_req,
    input  arb_gnt_t   i_last,
    output arb_gnt_t   o_gnt,
    output logic       o_valid
);

    always_comb begin
        o_valid = |i_req;
        o_gnt   = GNT_IC;
        if (i_req[c_REQ_IC] && i_req[c_REQ_DC]) begin
            o_gnt = other_gnt(i_last);
        end else if (i_req[c_REQ_DC]) begin
            o_gnt = GNT_DC;
        end else begin
            o_gnt = GNT_IC;
        end
    end

endmodule
`default_nettype wire

// File: rtl/riscv_core_cache_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : riscv_core_cache_mem_arbiter
// Description : Shares one AXI refill/writeback port between the icache and
//               dcache controllers. Round-robin between the two, one
//               transaction per grant (request .. i_axi_done), followed by a
//               single dead RELEASE cycle so a requester can drop its level
//               request before it could be re-granted.
// Ports       : i_clk / i_rst           clock, synchronous active-high reset
//               i_ic_req/i_ic_addr      icache refill request and line address
//               o_ic_done               icache completion pulse
//               i_dc_req/addr/we/wdata  dcache request, address, write flag,
//                                       writeback line
//               o_dc_done               dcache completion pulse
//               o_axi_req/addr/we/wdata request to the AXI master (latched)
//               i_axi_done              AXI completion pulse
//               o_busy                  transaction outstanding
//               o_timeout_err           sticky watchdog flag
// Revision    : 1.0  initial release
// ============================================================================
module riscv_core_cache_mem_arbiter
    import riscv_core_cache_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH     = 32,
    parameter int unsigned AXI_DATA_WIDTH = 256,
    parameter int unsigned TIMEOUT_CYCLES = 1024
)
(
    input  logic                      i_clk,
    input  logic                      i_rst,
    input  logic                      i_ic_req,
    input  logic [ADDR_WIDTH-1:0]     i_ic_addr,
    output logic                      o_ic_done,
    input  logic                      i_dc_req,
    input  logic [ADDR_WIDTH-1:0]     i_dc_addr,
    input  logic                      i_dc_we,
    input  logic [AXI_DATA_WIDTH-1:0] i_dc_wdata,
    output logic                      o_dc_done,
    output logic                      o_axi_req,
    output logic [ADDR_WIDTH-1:0]     o_axi_addr,
    output logic                      o_axi_we,
    output logic [AXI_DATA_WIDTH-1:0] o_axi_wdata,
    input  logic                      i_axi_done,
    output logic                      o_busy,
    output logic                      o_timeout_err
);

    // Counter only needs to reach TIMEOUT_CYCLES-1, where it parks.
    localparam int unsigned            c_WDOG_W   = $clog2(TIMEOUT_CYCLES);
    localparam logic [c_WDOG_W-1:0]    c_WDOG_MAX = c_WDOG_W'(TIMEOUT_CYCLES - 1);

    arb_state_t                  r_state;
    arb_state_t                  w_state_nxt;
    arb_gnt_t                    r_last;
    arb_gnt_t                    r_gnt;
    logic [ADDR_WIDTH-1:0]       r_addr;
    logic                        r_we;
    logic [AXI_DATA_WIDTH-1:0]   r_wdata;
    logic [c_WDOG_W-1:0]         r_wdog;
    logic                        r_timeout;

    arb_gnt_t                    w_pick_gnt;
    logic                        w_pick_valid;
    logic                        w_grant_en;
    logic                        w_done_hit;

    riscv_core_rr_pick2 u_pick (
        .i_req   ({i_dc_req, i_ic_req}),
        .i_last  (r_last),
        .o_gnt   (w_pick_gnt),
        .o_valid (w_pick_valid)
    );

    // ------------------------------------------------------------------
    // FSM state register
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= ARB_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // FSM next state and outputs
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_grant_en  = 1'b0;
        w_done_hit  = 1'b0;
        o_axi_req   = 1'b0;
        o_busy      = 1'b0;
        o_ic_done   = 1'b0;
        o_dc_done   = 1'b0;

        case (r_state)
            ARB_IDLE: begin
                if (w_pick_valid) begin
                    w_grant_en  = 1'b1;
                    w_state_nxt = ARB_BUSY;
                end
            end
            ARB_BUSY: begin
                o_axi_req = 1'b1;
                o_busy    = 1'b1;
                if (i_axi_done) begin
                    w_done_hit  = 1'b1;
                    w_state_nxt = ARB_RELEASE;
                end
            end
            ARB_RELEASE: begin
                w_state_nxt = ARB_IDLE;
            end
            default: begin
                w_state_nxt = ARB_IDLE;
            end
        endcase

        // A requester that withdrew (flush) does not see the completion.
        o_ic_done = w_done_hit && (r_gnt == GNT_IC) && i_ic_req;
        o_dc_done = w_done_hit && (r_gnt == GNT_DC) && i_dc_req;
    end

    // ------------------------------------------------------------------
    // Grant latch: fields frozen for the life of the transaction
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_last  <= GNT_DC;    // icache wins the first tie
            r_gnt   <= GNT_IC;
            r_addr  <= '0;
            r_we    <= 1'b0;
            r_wdata <= '0;
        end else if (w_grant_en) begin
            r_gnt  <= w_pick_gnt;
            r_last <= w_pick_gnt;
            if (w_pick_gnt == GNT_IC) begin
                r_addr  <= i_ic_addr;
                r_we    <= 1'b0;
                r_wdata <= '0;
            end else begin
                r_addr  <= i_dc_addr;
                r_we    <= i_dc_we;
                r_wdata <= i_dc_wdata;
            end
        end
    end

    // ------------------------------------------------------------------
    // Watchdog: counts BUSY cycles, flag is sticky until reset
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wdog    <= '0;
            r_timeout <= 1'b0;
        end else if (r_state == ARB_BUSY) begin
            if (r_wdog == c_WDOG_MAX) begin
                r_timeout <= 1'b1;
            end else begin
                r_wdog <= r_wdog + c_WDOG_W'(1);
            end
        end else begin
            r_wdog <= '0;
        end
    end

    assign o_axi_addr    = r_addr;
    assign o_axi_we      = r_we;
    assign o_axi_wdata   = r_wdata;
    assign o_timeout_err = r_timeout;

endmodule
`default_nettype wire
